// File: rtl/prince_mask_pkg.sv
// Shared constants and types for the masked PRINCE S-box share feeder:
// share/nibble widths, randomness widths, LFSR taps, the zero-seed
// substitute and the feeder FSM state encoding.
package prince_mask_pkg;

    localparam int NSHARES     = 3;
    localparam int NIB_W       = 4;
    localparam int RAND_R_W    = 18;
    localparam int RAND_KLMN_W = 4;
    localparam int LFSR_W      = 64;
    localparam int STEP_BITS   = 32;

    // Fibonacci taps, 1-based bit positions (x^64 + x^63 + x^61 + x^60 + 1)
    localparam int TAP_A = 64;
    localparam int TAP_B = 63;
    localparam int TAP_C = 61;
    localparam int TAP_D = 60;

    // An all-zero LFSR would lock up, so a zero seed is replaced by this
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 64'h0123_4567_89AB_CDEF;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        WARMUP   = 2'd1,
        RUN      = 2'd2
    } feeder_state_e;

    // Seed actually loaded into the LFSR
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? ZERO_SEED_SUB : s;
    endfunction

endpackage

// File: rtl/prince_lfsr64_step32.sv
// Pure combinational next-state of the 64-bit Fibonacci LFSR advanced by
// 32 single-bit steps. Each step shifts left and inserts the feedback bit
// at bit 0, so after 32 steps bits [31:0] hold the 32 freshly generated
// bits (bit 31 oldest).
module prince_lfsr64_step32
    import prince_mask_pkg::*;
(
    input  logic [LFSR_W-1:0] lfsr,
    output logic [LFSR_W-1:0] lfsr_next
);

    logic [LFSR_W-1:0] work;

    // Unrolled chain of 32 single-bit LFSR steps
    always_comb begin
        work = lfsr;
        for (int i = 0; i < STEP_BITS; i++) begin
            work = {work[LFSR_W-2:0],
                    work[TAP_A-1] ^ work[TAP_B-1] ^ work[TAP_C-1] ^ work[TAP_D-1]};
        end
        lfsr_next = work;
    end

endmodule

// File: rtl/prince_sbox_share_feeder.sv
// Feeds refreshed 3-share nibbles plus fresh randomness to a masked PRINCE
// S-box stage. A 64-bit LFSR supplies 32 random bits per clock; shares are
// remasked on accept, otherwise a fresh sharing of zero is emitted.
// Optional build macro: PRINCE_FEEDER_WARMUP_EN adds a WARMUP phase that
// discards WARMUP_CYCLES LFSR steps after each seed load.
//
// Handshake: a nibble is transferred in a cycle where in_valid and in_ready
// are both 1. in_ready is 1 only in RUN and never in a seed_load cycle. The
// downstream stage never stalls, so there is no output-side ready.
module prince_sbox_share_feeder
    import prince_mask_pkg::*;
#(
    parameter int WARMUP_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   seed_load,
    input  logic [LFSR_W-1:0]      seed,
    input  logic [NIB_W-1:0]       in1,
    input  logic [NIB_W-1:0]       in2,
    input  logic [NIB_W-1:0]       in3,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NIB_W-1:0]       sbox_in1,
    output logic [NIB_W-1:0]       sbox_in2,
    output logic [NIB_W-1:0]       sbox_in3,
    output logic [RAND_R_W-1:0]    sbox_r,
    output logic [RAND_KLMN_W-1:0] sbox_klmn,
    output logic                   sbox_valid,
    output logic                   res_valid,
    output logic [3:0]             res_idx,
    output logic                   res_last,
    output logic [1:0]             fsm_state
);

    feeder_state_e     state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_step;
    logic [31:0]       rnd;
    logic [NIB_W-1:0]  m0, m1;
    logic [NIB_W-1:0]  d1, d2, d3;
    logic              active;
    logic              accept;
    logic [3:0]        idx_q;
    logic [3:0]        sbox_idx_q;
    logic [1:0]        unused_rnd_bits;

    prince_lfsr64_step32 u_step (
        .lfsr      (lfsr_q),
        .lfsr_next (lfsr_step)
    );

    assign rnd             = lfsr_step[31:0];
    assign m0              = rnd[3:0];
    assign m1              = rnd[7:4];
    assign unused_rnd_bits = rnd[31:30];
    assign active          = (state_q != UNSEEDED);
    assign accept          = in_valid & in_ready;
    assign fsm_state       = state_q;

`ifdef PRINCE_FEEDER_WARMUP_EN
    localparam feeder_state_e SEED_NEXT = WARMUP;
    localparam int CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    logic [CNT_W-1:0] warm_cnt_q;
    logic             warm_done;

    assign warm_done = (warm_cnt_q == CNT_W'(WARMUP_CYCLES - 1));

    // Warm-up counter: restarts on every seed load, counts while warming up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_q <= '0;
        end else if (seed_load) begin
            warm_cnt_q <= '0;
        end else if (state_q == WARMUP) begin
            warm_cnt_q <= warm_cnt_q + 1'b1;
        end
    end
`else
    localparam feeder_state_e SEED_NEXT = RUN;
    localparam int unused_warmup_cycles = WARMUP_CYCLES;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNSEEDED;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and in_ready; a seed load overrides everything
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            UNSEEDED: state_d = UNSEEDED;
`ifdef PRINCE_FEEDER_WARMUP_EN
            WARMUP:   if (warm_done) state_d = RUN;
`else
            WARMUP:   state_d = RUN;
`endif
            RUN:      in_ready = 1'b1;
            default:  state_d = UNSEEDED;
        endcase
        if (seed_load) begin
            state_d  = SEED_NEXT;
            in_ready = 1'b0;
        end
    end

    // LFSR: load (zero-substituted) seed, else advance 32 bits when seeded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else if (seed_load) begin
            lfsr_q <= seed_fix(seed);
        end else if (active) begin
            lfsr_q <= lfsr_step;
        end
    end

    // Data presented to the remasking XOR: the nibble on accept, else zero
    always_comb begin
        d1 = '0;
        d2 = '0;
        d3 = '0;
        if (accept) begin
            d1 = in1;
            d2 = in2;
            d3 = in3;
        end
    end

    // S-box stage registers: remasked shares and fresh randomness
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbox_in1   <= '0;
            sbox_in2   <= '0;
            sbox_in3   <= '0;
            sbox_r     <= '0;
            sbox_klmn  <= '0;
            sbox_valid <= 1'b0;
            sbox_idx_q <= '0;
        end else begin
            sbox_valid <= accept;
            if (active) begin
                sbox_in1  <= d1 ^ m0;
                sbox_in2  <= d2 ^ m1;
                sbox_in3  <= d3 ^ m0 ^ m1;
                sbox_r    <= rnd[25:8];
                sbox_klmn <= rnd[29:26];
            end
            if (accept) begin
                sbox_idx_q <= idx_q;
            end
        end
    end

    // Nibble index: restarts on seed load, advances per accepted nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (seed_load) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= idx_q + 4'd1;
        end
    end

    // Result tag, one cycle behind the S-box stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_last  <= 1'b0;
        end else begin
            res_valid <= sbox_valid;
            res_idx   <= sbox_idx_q;
            res_last  <= (sbox_idx_q == 4'hF);
        end
    end

endmodule

// File: doc/prince_sbox_share_feeder.md
PRINCE_SBOX_SHARE_FEEDER -- requirements
Module: prince_sbox_share_feeder

Interface
REQ-001 SHALL have parameter WARMUP_CYCLES, default 64, meaning LFSR steps discarded after a seed load.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  reset; one clock, asynchronous active-low reset.
REQ-004 SHALL have port seed_load  in  1  load seed this cycle.
REQ-005 SHALL have port seed  in  64  PRNG seed.
REQ-006 SHALL have ports in1/in2/in3  in  4 each  shares 0/1/2 of the unmasked nibble.
REQ-007 SHALL have ports in_valid (in, 1) and in_ready (out, 1)  input handshake.
REQ-008 SHALL have ports sbox_in1/sbox_in2/sbox_in3  out  4 each  refreshed shares to the S-box stage.
REQ-009 SHALL have port sbox_r  out  18  fresh randomness for the S-box stage.
REQ-010 SHALL have port sbox_klmn  out  4  fresh randomness for the S-box stage.
REQ-011 SHALL have port sbox_valid  out  1  sbox_in* carry a real nibble.
REQ-012 SHALL have ports res_valid (out, 1), res_idx (out, 4) and res_last (out, 1)  S-box result tag, one cycle after sbox_valid.

Function
REQ-013 SHALL implement FSM UNSEEDED -> WARMUP -> RUN; seed_load in any state goes to WARMUP; WARMUP goes to RUN when the warm-up counter reaches WARMUP_CYCLES-1.
REQ-014 SHALL drive in_ready = 1 only in RUN, and not in a cycle where seed_load = 1.
REQ-015 SHALL accept a nibble on in_valid & in_ready; the downstream stage never stalls, so no back-pressure exists beyond in_ready.
REQ-016 SHALL keep a 64-bit Fibonacci LFSR (taps 64,63,61,60) advanced 32 bits per clock in WARMUP and RUN; held in UNSEEDED.
REQ-017 SHALL on seed_load with seed == 0 load 64'h0123_4567_89AB_CDEF instead of zero.
REQ-018 SHALL slice the 32 LFSR bits per cycle as: m0 = [3:0], m1 = [7:4], sbox_r = [25:8], sbox_klmn = [29:26]; bits [31:30] unused.
REQ-019 SHALL register, on accept, sbox_in1 = in1^m0, sbox_in2 = in2^m1, sbox_in3 = in3^m0^m1, with sbox_valid = 1 (latency 1 cycle).
REQ-020 SHALL register, when no nibble is accepted, sbox_in1 = m0, sbox_in2 = m1, sbox_in3 = m0^m1 (a fresh sharing of zero), with sbox_valid = 0.
REQ-021 SHALL register sbox_r and sbox_klmn every cycle in WARMUP and RUN, aligned with sbox_in*.
REQ-022 SHALL drive res_valid = sbox_valid delayed one cycle; res_idx and res_last travel with it.
REQ-023 SHALL keep a 4-bit nibble index, incremented per accept, wrapping 15 -> 0; res_last = 1 iff res_idx == 15.
REQ-024 SHALL, on seed_load mid-RUN, let an already-registered nibble complete its res_valid, reset the index to 0, and accept nothing until RUN is re-entered.
REQ-025 SHALL ignore in_valid outside RUN, with no state change.

Reset
REQ-026 SHALL on rst_n low asynchronously clear all registers and all outputs to 0.
REQ-027 SHALL enter state UNSEEDED with index 0 and the warm-up counter at 0 on reset.
REQ-028 SHALL leave all outputs 0 after reset release until the first seed_load.

Configuration
REQ-029 SHALL implement WARMUP when macro PRINCE_FEEDER_WARMUP_EN is defined.
REQ-030 SHALL, without PRINCE_FEEDER_WARMUP_EN, go directly from seed_load to RUN in the next cycle, with no warm-up counter and WARMUP_CYCLES unused.

Structure
REQ-031 SHALL take from package prince_mask_pkg: NSHARES = 3, NIB_W = 4, RAND_R_W = 18, RAND_KLMN_W = 4, LFSR_W = 64, tap constants, the zero-seed substitute constant, and the FSM state enum.
REQ-032 SHALL place the unrolled 32-step LFSR next-state function in sub-module prince_lfsr64_step32.

Verification
REQ-033 SHALL cover: reset, then seed_load with seed = 64'h1 and macro on -> in_ready stays 0 for 64 cycles, then rises in cycle 65.
REQ-034 SHALL cover: in RUN, accept in1 = 4'h3, in2 = 4'h5, in3 = 4'hA -> next cycle sbox_valid = 1 and sbox_in1^sbox_in2^sbox_in3 = 4'hC, and sbox_in1 == in1^m0 checked against a reference LFSR model.
REQ-035 SHALL cover: 17 back-to-back accepts -> res_idx runs 0..15 then 0, res_last = 1 only on the 16th, and res_valid lags sbox_valid by exactly 1 cycle.
REQ-036 SHALL cover: seed_load = 1 together with in_valid = 1 in RUN -> not accepted, the previous nibble still produces res_valid, and the next accepted nibble has res_idx = 0.
REQ-037 SHALL cover: seed = 0 -> LFSR state equals 64'h0123_4567_89AB_CDEF one cycle later, and sbox_r never stays constant across 100 cycles.
REQ-038 SHALL cover: rst_n asserted mid-RUN, asynchronously -> all outputs 0 within the same cycle, state UNSEEDED, and in_valid ignored afterwards.
